// File: rtl/clk_div_ctrl_pkg.sv
// Shared FSM encoding and ratio constants for the clock-divider controller.
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StLoad  = 2'd2,
        StRun   = 2'd3
    } ctrl_state_e;

    localparam int unsigned RATIO_BYPASS  = 1;
    localparam int unsigned RATIO_INVALID = 0;

endpackage

// File: rtl/clk_div_ctrl_period_mon.sv
// Checks the divided-clock feedback period against the programmed ratio and
// reports lock after enough consecutive matching periods.
module clk_div_ctrl_period_mon
    import clk_div_ctrl_pkg::*;
#(
    parameter int unsigned RATIO_WIDTH  = 8,
    parameter int unsigned LOCK_PERIODS = 2
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_run,
    input  logic [RATIO_WIDTH-1:0] i_ratio,
    input  logic                   i_fb,
    output logic                   o_locked
);

    localparam int unsigned GoodW = $clog2(LOCK_PERIODS + 1);
    localparam logic [RATIO_WIDTH-1:0] Bypass   = RATIO_WIDTH'(RATIO_BYPASS);
    localparam logic [GoodW-1:0]       GoodLock = GoodW'(LOCK_PERIODS);

    logic                   fb_q, armed_q, armed_d, locked_q, locked_d, fb_rise;
    logic [RATIO_WIDTH-1:0] period_q, period_d;
    logic [GoodW-1:0]       good_q, good_d;

    always_comb begin
        fb_rise  = i_fb && !fb_q;
        period_d = period_q;
        good_d   = good_q;
        armed_d  = armed_q;
        if (!i_run || (i_ratio == Bypass)) begin
            period_d = '0;
            good_d   = '0;
            armed_d  = 1'b0;
        end else if (fb_rise) begin
            period_d = RATIO_WIDTH'(1);
            // The first edge only starts timing; there is no prior period to judge.
            if (!armed_q) begin
                armed_d = 1'b1;
            end else if (period_q == i_ratio) begin
                if (good_q != GoodLock) good_d = good_q + 1'b1;
            end else begin
                good_d = '0;
            end
        end else begin
            if (period_q != '1) period_d = period_q + 1'b1;
            if (armed_q && (period_q > i_ratio)) good_d = '0;
        end
        locked_d = i_run && ((i_ratio == Bypass) || (good_d == GoodLock));
    end

    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            fb_q     <= 1'b0;
            armed_q  <= 1'b0;
            period_q <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            fb_q     <= i_fb;
            armed_q  <= armed_d;
            period_q <= period_d;
            good_q   <= good_d;
            locked_q <= locked_d;
        end
    end

    assign o_locked = locked_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: ratio handshake, settle-gated ratio updates and
// enable control, with a feedback period monitor for lock detection.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int unsigned RATIO_WIDTH   = 8,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LOCK_PERIODS  = 2,
    parameter int unsigned RESET_RATIO   = 8
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic                   i_cfg_valid,
    input  logic [RATIO_WIDTH-1:0] i_cfg_ratio,
    output logic                   o_cfg_ready,
    output logic                   o_cfg_err,
    input  logic                   i_div_clk_fb,
    output logic [RATIO_WIDTH-1:0] o_div_ratio,
    output logic                   o_clk_en,
    output logic                   o_busy,
    output logic                   o_locked
);

    localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SettleW-1:0]     SettleLast = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [RATIO_WIDTH-1:0] ResetRatio = RATIO_WIDTH'(RESET_RATIO);
    localparam logic [RATIO_WIDTH-1:0] Bypass     = RATIO_WIDTH'(RATIO_BYPASS);
    localparam logic [RATIO_WIDTH-1:0] Invalid    = RATIO_WIDTH'(RATIO_INVALID);

    ctrl_state_e            state_q;
    logic [SettleW-1:0]     settle_q;
    logic [RATIO_WIDTH-1:0] pend_ratio_q, div_ratio_q;
    logic                   clk_en_q, cfg_err_q, busy_q, ready_q;
    logic                   cfg_hit, cfg_accept, cfg_reject, stay_run;

    always_comb begin
        cfg_hit    = i_cfg_valid && ready_q;
        cfg_reject = cfg_hit && (i_cfg_ratio == Invalid);
        cfg_accept = cfg_hit && !cfg_reject;
        // Monitor runs only while RUN persists, so leaving RUN clears it on the same edge.
        stay_run   = (state_q == StRun) && i_enable && !cfg_accept;
    end

    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= StIdle;
            settle_q     <= '0;
            pend_ratio_q <= ResetRatio;
            div_ratio_q  <= ResetRatio;
            clk_en_q     <= 1'b0;
            cfg_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            cfg_err_q <= cfg_reject;
            if (cfg_accept) pend_ratio_q <= i_cfg_ratio;
            unique case (state_q)
                StIdle, StRun: begin
                    if (cfg_accept) begin
                        state_q  <= StDrain;
                        settle_q <= '0;
                        clk_en_q <= 1'b0;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                    end else if ((state_q == StIdle) && i_enable) begin
                        state_q  <= StRun;
                        clk_en_q <= (div_ratio_q != Bypass);
                    end else if ((state_q == StRun) && !i_enable) begin
                        state_q  <= StIdle;
                        clk_en_q <= 1'b0;
                    end
                end
                StDrain: begin
                    if (settle_q == SettleLast) state_q <= StLoad;
                    else                        settle_q <= settle_q + 1'b1;
                end
                StLoad: begin
                    div_ratio_q <= pend_ratio_q;
                    busy_q      <= 1'b0;
                    ready_q     <= 1'b1;
                    if (i_enable) begin
                        state_q  <= StRun;
                        clk_en_q <= (pend_ratio_q != Bypass);
                    end else begin
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    clk_div_ctrl_period_mon #(
        .RATIO_WIDTH  (RATIO_WIDTH),
        .LOCK_PERIODS (LOCK_PERIODS)
    ) u_period_mon (
        .i_ref_clk (i_ref_clk),
        .i_rst     (i_rst),
        .i_run     (stay_run),
        .i_ratio   (div_ratio_q),
        .i_fb      (i_div_clk_fb),
        .o_locked  (o_locked)
    );

    assign o_cfg_ready = ready_q;
    assign o_cfg_err   = cfg_err_q;
    assign o_div_ratio = div_ratio_q;
    assign o_clk_en    = clk_en_q;
    assign o_busy      = busy_q;

endmodule
